audio_mixer: RTL and testbench



---
 rtl/audio_mixer.sv | 145 ++++++++++++++
 tb/tb_audio_mixer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// Multi-channel audio mixer: per-channel gain, mute and master gain, with
// saturation to the sample width and a buffer write of each mixed frame.
module audio_mixer #(
  parameter int NUM_CH      = 6,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 256,
  localparam int AW         = $clog2(BUF_LEN)
) (
  input  logic                            mclk,
  input  logic                            rst,
  input  logic                            sample_tick,
  input  logic [NUM_CH*SAMPLE_BITS-1:0]   ch_sample,
  input  logic [NUM_CH*VOLUME_BITS-1:0]   ch_vol,
  input  logic [NUM_CH-1:0]               ch_mute,
  input  logic [VOLUME_BITS-1:0]          master_vol,
  input  logic [AW-1:0]                   play_index,
  input  logic                            clr_flags,
  output logic                            buf_we,
  output logic [AW-1:0]                   buf_addr,
  output logic [SAMPLE_BITS-1:0]          buf_wdata,
  output logic                            busy,
  output logic                            clip,
  output logic                            overrun
);

  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W  = SAMPLE_BITS + VOLUME_BITS + 1;
  localparam int ACC_W   = SAMPLE_BITS + 2*VOLUME_BITS + $clog2(NUM_CH) + 1;
  localparam int MPROD_W = ACC_W + VOLUME_BITS + 1;
  localparam int SHIFT   = 2*VOLUME_BITS;

  localparam logic signed [MPROD_W-1:0] SAT_MAX =
    MPROD_W'($signed({1'b0, {(SAMPLE_BITS-1){1'b1}}}));
  localparam logic signed [MPROD_W-1:0] SAT_MIN =
    MPROD_W'($signed({1'b1, {(SAMPLE_BITS-1){1'b0}}}));

  typedef enum logic [2:0] {IDLE, ACCUM, MASTER, SAT, WRITE} state_t;

  state_t state_q, state_d;

  logic [NUM_CH*SAMPLE_BITS-1:0] smp_q;
  logic [NUM_CH*VOLUME_BITS-1:0] vol_q;
  logic [NUM_CH-1:0]             mute_q;
  logic [VOLUME_BITS-1:0]        mvol_q;
  logic [AW-1:0]                 addr_q;
  logic [CW-1:0]                 idx_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic signed [MPROD_W-1:0]     scaled_q;

  logic signed [SAMPLE_BITS-1:0] cur_sample;
  logic signed [VOLUME_BITS:0]   cur_gain;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       term;
  logic signed [MPROD_W-1:0]     mprod;
  logic [SAMPLE_BITS-1:0]        sat_val;
  logic                          sat_hit;
  logic                          last_ch;

  assign busy    = (state_q != IDLE);
  assign buf_we  = (state_q == WRITE);
  assign last_ch = (idx_q == CW'(NUM_CH-1));

  always_ff @(posedge mclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = ACCUM;
      ACCUM:   if (last_ch)     state_d = MASTER;
      MASTER:  state_d = SAT;
      SAT:     state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gains are unsigned, so a zero bit is prepended before the signed multiply.
  always_comb begin
    cur_sample = $signed(smp_q[idx_q*SAMPLE_BITS +: SAMPLE_BITS]);
    cur_gain   = $signed({1'b0, vol_q[idx_q*VOLUME_BITS +: VOLUME_BITS]});
    prod       = PROD_W'(cur_sample) * PROD_W'(cur_gain);
    term       = mute_q[idx_q] ? '0 : ACC_W'(prod);
    mprod      = MPROD_W'(acc_q) * MPROD_W'($signed({1'b0, mvol_q}));
    sat_hit    = 1'b0;
    sat_val    = scaled_q[SAMPLE_BITS-1:0];
    if (scaled_q > SAT_MAX) begin
      sat_hit = 1'b1;
      sat_val = SAT_MAX[SAMPLE_BITS-1:0];
    end else if (scaled_q < SAT_MIN) begin
      sat_hit = 1'b1;
      sat_val = SAT_MIN[SAMPLE_BITS-1:0];
    end
  end

  // Outputs are loaded on the SAT->WRITE edge so they hold until the next frame's write.
  always_ff @(posedge mclk) begin
    if (rst) begin
      smp_q     <= '0;
      vol_q     <= '0;
      mute_q    <= '0;
      mvol_q    <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      scaled_q  <= '0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sample_tick) begin
          smp_q  <= ch_sample;
          vol_q  <= ch_vol;
          mute_q <= ch_mute;
          mvol_q <= master_vol;
          addr_q <= play_index - AW'(1);
          acc_q  <= '0;
          idx_q  <= '0;
        end
        ACCUM: begin
          acc_q <= acc_q + term;
          idx_q <= idx_q + CW'(1);
        end
        MASTER: scaled_q <= mprod >>> SHIFT;
        SAT: begin
          buf_wdata <= sat_val;
          buf_addr  <= addr_q;
        end
        default: ;
      endcase

      if (state_q == SAT && sat_hit) clip <= 1'b1;
      else if (clr_flags)            clip <= 1'b0;

      if (sample_tick && state_q != IDLE) overrun <= 1'b1;
      else if (clr_flags)                 overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Directed-vector bench for audio_mixer (6 channels, 16-bit samples, 8-bit gains).
module tb_audio_mixer;

  logic        mclk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic [95:0] ch_sample;
  logic [47:0] ch_vol;
  logic [5:0]  ch_mute;
  logic [7:0]  master_vol;
  logic [7:0]  play_index;
  logic        clr_flags;
  logic        buf_we;
  logic [7:0]  buf_addr;
  logic [15:0] buf_wdata;
  logic        busy;
  logic        clip;
  logic        overrun;

  int n_vec = 0;
  int n_bad = 0;

  always #5 mclk = ~mclk;

  audio_mixer #(.NUM_CH(6), .SAMPLE_BITS(16), .VOLUME_BITS(8), .BUF_LEN(256)) dut (
    .mclk(mclk), .rst(rst), .sample_tick(sample_tick), .ch_sample(ch_sample),
    .ch_vol(ch_vol), .ch_mute(ch_mute), .master_vol(master_vol),
    .play_index(play_index), .clr_flags(clr_flags), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .busy(busy), .clip(clip),
    .overrun(overrun)
  );

  typedef struct {
    logic [95:0] smp;
    logic [47:0] vol;
    logic [5:0]  mute;
    logic [7:0]  mvol;
    logic [7:0]  pi;
    bit          clr;
    int          exp_data;
    int          exp_addr;
    bit          exp_clip;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [95:0] s6(int c0, int c1, int c2, int c3, int c4, int c5);
    return {16'(c5), 16'(c4), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  function automatic logic [47:0] v6(int c0, int c1, int c2, int c3, int c4, int c5);
    return {8'(c5), 8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ch_sample  = v.smp;
    ch_vol     = v.vol;
    ch_mute    = v.mute;
    master_vol = v.mvol;
    play_index = v.pi;
  endtask

  task automatic run_frame(input vec_t v, input bit hold_clr, input string tag);
    int cnt;
    if (v.clr) begin
      @(negedge mclk) clr_flags = 1'b1;
      @(negedge mclk) clr_flags = 1'b0;
    end
    @(negedge mclk);
    drive(v);
    sample_tick = 1'b1;
    clr_flags   = hold_clr;
    @(negedge mclk);
    sample_tick = 1'b0;
    ch_sample   = ~ch_sample;
    ch_vol      = ~ch_vol;
    ch_mute     = ~ch_mute;
    master_vol  = ~master_vol;
    play_index  = play_index + 8'd5;
    cnt = 1;
    while (!buf_we && cnt < 40) begin
      @(negedge mclk);
      cnt++;
    end
    chk({tag, ".latency"}, cnt, 9);
    chk({tag, ".wdata"}, $signed(buf_wdata), v.exp_data);
    chk({tag, ".addr"}, buf_addr, v.exp_addr);
    chk({tag, ".clip"}, clip, v.exp_clip);
    chk({tag, ".overrun"}, overrun, 0);
    @(negedge mclk);
    chk({tag, ".we_width"}, buf_we, 0);
    clr_flags = 1'b0;
  endtask

  initial begin
    int n_we;
    int got_data;
    int got_addr;

    tbl[0] = '{smp: s6(1000, 0, 0, 0, 0, 0), vol: v6(128, 0, 0, 0, 0, 0), mute: 6'b111110,
               mvol: 8'd255, pi: 8'd10, clr: 1'b0, exp_data: 498, exp_addr: 9, exp_clip: 1'b0};
    tbl[1] = '{smp: s6(32767, 32767, 32767, 32767, 32767, 32767), vol: v6(255, 255, 255, 255, 255, 255),
               mute: 6'b000000, mvol: 8'd255, pi: 8'd20, clr: 1'b0, exp_data: 32767, exp_addr: 19, exp_clip: 1'b1};
    tbl[2] = '{smp: s6(-32768, -32768, 0, 0, 0, 0), vol: v6(255, 255, 255, 255, 255, 255), mute: 6'b111100,
               mvol: 8'd255, pi: 8'd30, clr: 1'b1, exp_data: -32768, exp_addr: 29, exp_clip: 1'b1};
    tbl[3] = '{smp: s6(-1, 0, 0, 0, 0, 0), vol: v6(1, 0, 0, 0, 0, 0), mute: 6'b111110,
               mvol: 8'd255, pi: 8'd30, clr: 1'b1, exp_data: -1, exp_addr: 29, exp_clip: 1'b0};
    tbl[4] = '{smp: s6(1000, 0, 0, 0, 0, 0), vol: v6(128, 0, 0, 0, 0, 0), mute: 6'b000001,
               mvol: 8'd255, pi: 8'd0, clr: 1'b0, exp_data: 0, exp_addr: 255, exp_clip: 1'b0};
    tbl[5] = '{smp: s6(1000, -2000, 300, 5000, 5000, 5000), vol: v6(255, 100, 10, 200, 200, 200),
               mute: 6'b111000, mvol: 8'd128, pi: 8'd100, clr: 1'b0, exp_data: 113, exp_addr: 99, exp_clip: 1'b0};
    tbl[6] = '{smp: s6(-1000, 0, 0, 0, 0, 0), vol: v6(128, 0, 0, 0, 0, 0), mute: 6'b111110,
               mvol: 8'd255, pi: 8'd1, clr: 1'b0, exp_data: -499, exp_addr: 0, exp_clip: 1'b0};
    tbl[7] = '{smp: s6(32767, 32767, 32767, 32767, 32767, 32767), vol: v6(255, 255, 255, 255, 255, 255),
               mute: 6'b000000, mvol: 8'd0, pi: 8'd255, clr: 1'b0, exp_data: 0, exp_addr: 254, exp_clip: 1'b0};

    rst = 1'b1;
    sample_tick = 1'b0;
    clr_flags = 1'b0;
    drive(tbl[0]);
    repeat (2) @(negedge mclk);
    sample_tick = 1'b1;
    @(negedge mclk);
    sample_tick = 1'b0;
    rst = 1'b0;
    @(negedge mclk);
    chk("reset.buf_we", buf_we, 0);
    chk("reset.buf_addr", buf_addr, 0);
    chk("reset.buf_wdata", buf_wdata, 0);
    chk("reset.busy", busy, 0);
    chk("reset.clip", clip, 0);
    chk("reset.overrun", overrun, 0);

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i], 1'b0, $sformatf("vec%0d", i));
      repeat (2) @(negedge mclk);
    end

    // clr_flags held across a clipping frame: the set must win, then clear
    run_frame(tbl[1], 1'b1, "clr_vs_set");
    chk("clr_vs_set.cleared", clip, 0);

    // second tick while busy: dropped, first frame written, overrun flagged
    @(negedge mclk);
    drive(tbl[0]);
    sample_tick = 1'b1;
    @(negedge mclk);
    sample_tick = 1'b0;
    chk("ovr.busy", busy, 1);
    @(negedge mclk);
    ch_sample = s6(2000, 0, 0, 0, 0, 0);
    play_index = 8'd50;
    sample_tick = 1'b1;
    @(negedge mclk);
    sample_tick = 1'b0;
    n_we = 0;
    got_data = 0;
    got_addr = 0;
    for (int c = 0; c < 20; c++) begin
      if (buf_we) begin
        n_we++;
        got_data = $signed(buf_wdata);
        got_addr = buf_addr;
      end
      @(negedge mclk);
    end
    chk("ovr.we_count", n_we, 1);
    chk("ovr.wdata", got_data, 498);
    chk("ovr.addr", got_addr, 9);
    chk("ovr.flag", overrun, 1);

    // reset during ACCUM: frame aborted, everything back to zero
    @(negedge mclk);
    drive(tbl[1]);
    sample_tick = 1'b1;
    @(negedge mclk);
    sample_tick = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    n_we = 0;
    for (int c = 0; c < 15; c++) begin
      if (buf_we) n_we++;
      @(negedge mclk);
    end
    chk("rst_mid.we_count", n_we, 0);
    chk("rst_mid.buf_addr", buf_addr, 0);
    chk("rst_mid.buf_wdata", buf_wdata, 0);
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.clip", clip, 0);
    chk("rst_mid.overrun", overrun, 0);
    run_frame(tbl[0], 1'b0, "rst_mid.after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
